// File: rtl/shift_request_queue_if.sv
// Handshake bundle between the request producer, the external shifter and the result consumer.
// The master modport is the environment side; the slave modport is the queue itself.
interface shift_request_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AMT_W  = 3
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AMT_W-1:0]  in_amount;
    logic              in_dir;
    logic [DATA_W-1:0] shf_data;
    logic [AMT_W-1:0]  shf_amount;
    logic              shf_dir;
    logic [DATA_W-1:0] shf_result;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_data, in_amount, in_dir, shf_result, out_ready,
        input  in_ready, shf_data, shf_amount, shf_dir, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, in_amount, in_dir, shf_result, out_ready,
        output in_ready, shf_data, shf_amount, shf_dir, out_valid, out_data, count
    );
endinterface

// File: rtl/shift_request_queue.sv
// Request FIFO feeding a combinational shifter, with a registered, held result stage.
// No bypass: a request must sit at the FIFO head for one cycle before it can pop.
module shift_request_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AMT_W  = 3
) (
    input logic                 clk,
    input logic                 rst,
    shift_request_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + AMT_W + 1;
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              full, empty, push, pop;
    logic [ENT_W-1:0]  head;

    always_comb begin
        full  = (count_q == FullCnt);
        empty = (count_q == '0);
        // in_ready ignores a same-cycle pop, so a full queue never pushes through.
        push  = bus.in_valid && !full;
        pop   = !empty && (!out_valid_q || bus.out_ready);
        head  = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.shf_result;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage needs no reset; the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {bus.in_data, bus.in_amount, bus.in_dir};
        end
    end

    assign bus.in_ready   = !full;
    assign bus.count      = count_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.shf_data   = head[ENT_W-1 -: DATA_W];
    assign bus.shf_amount = head[AMT_W:1];
    assign bus.shf_dir    = head[0];
endmodule

// File: tb/tb_shift_request_queue.sv
// Directed bench for shift_request_queue: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_shift_request_queue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned AMT_W  = 3;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] amt;
        logic       dir;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_request_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AMT_W(AMT_W)) bus ();

    shift_request_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // External combinational shifter
    assign bus.shf_result = bus.shf_dir ? (bus.shf_data << bus.shf_amount)
                                        : (bus.shf_data >> bus.shf_amount);

    req_t       m_q[$];
    logic       m_ov;
    logic [7:0] m_od;
    logic [7:0] m_cons[$];
    bit         checking = 1'b0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         base;

    function automatic logic [7:0] shift_ref(input req_t r);
        return r.dir ? (r.data << r.amt) : (r.data >> r.amt);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit do_push;
        bit do_pop;
        req_t r;
        if (rst) begin
            m_q.delete();
            m_ov = 1'b0;
            m_od = 8'h00;
        end else begin
            do_push = bus.in_valid && (m_q.size() < DEPTH);
            do_pop  = (m_q.size() != 0) && (!m_ov || bus.out_ready);
            if (m_ov && bus.out_ready) m_cons.push_back(m_od);
            if (do_pop) begin
                r = m_q.pop_front();
                m_od = shift_ref(r);
                m_ov = 1'b1;
            end else if (m_ov && bus.out_ready) begin
                m_ov = 1'b0;
            end
            if (do_push) m_q.push_back('{bus.in_data, bus.in_amount, bus.in_dir});
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] a,
                         input logic dir, input logic ordy, input logic r);
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_amount = a;
        bus.in_dir    = dir;
        bus.out_ready = ordy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_empty_outputs(input string tag);
        check({tag, "_shf"}, {bus.shf_data, bus.shf_amount, bus.shf_dir}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (checking) begin
            req_t exp_head;
            exp_head = (m_q.size() != 0) ? m_q[0] : '0;
            check("cyc_count", bus.count, m_q.size());
            check("cyc_in_ready", bus.in_ready, m_q.size() < DEPTH);
            check("cyc_out_valid", bus.out_valid, m_ov);
            check("cyc_out_data", bus.out_data, m_od);
            check("cyc_head", {bus.shf_data, bus.shf_amount, bus.shf_dir}, exp_head);
        end
    end

    initial begin
        logic [7:0] t3_in [6];
        logic [7:0] t3_exp [5];
        t3_in  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        t3_exp = '{8'h22, 8'h44, 8'h66, 8'h88, 8'hAA};

        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amount = '0; bus.in_dir = 1'b0;
        bus.out_ready = 1'b0;

        // Reset
        cycle(0, 8'h00, 3'd0, 0, 0, 1);
        cycle(0, 8'h00, 3'd0, 0, 0, 1);
        checking = 1'b1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_count", bus.count, 0);
        check_empty_outputs("rst");

        // Single request, 2-edge latency
        cycle(1, 8'h81, 3'd1, 1, 1, 0);
        check("t1_accept_count", bus.count, 1);
        check("t1_accept_ov", bus.out_valid, 0);
        cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t1_ov", bus.out_valid, 1);
        check("t1_od", bus.out_data, 8'h02);
        check("t1_count", bus.count, 0);
        cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t1_model_cons", m_cons[0], 8'h02);
        check("t1_ov_fall", bus.out_valid, 0);

        // Back-to-back, no bubbles
        base = m_cons.size();
        cycle(1, 8'hF0, 3'd4, 0, 1, 0);
        cycle(1, 8'h0F, 3'd3, 1, 1, 0);
        check("t2_od0", bus.out_data, 8'h0F);
        cycle(1, 8'hA5, 3'd0, 0, 1, 0);
        check("t2_od1", bus.out_data, 8'h78);
        cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t2_od2", bus.out_data, 8'hA5);
        check("t2_ov", bus.out_valid, 1);
        cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t2_cons0", m_cons[base], 8'h0F);
        check("t2_cons1", m_cons[base+1], 8'h78);
        check("t2_cons2", m_cons[base+2], 8'hA5);

        // Back-pressure: fill FIFO plus output register, sixth request refused
        for (int i = 0; i < 6; i++) cycle(1, t3_in[i], 3'd1, 1, 0, 0);
        check("t3_count_full", bus.count, 4);
        check("t3_in_ready", bus.in_ready, 0);
        check("t3_ov", bus.out_valid, 1);
        check("t3_od_hold", bus.out_data, 8'h22);
        cycle(0, 8'h00, 3'd0, 0, 0, 0);
        cycle(0, 8'h00, 3'd0, 0, 0, 0);
        check("t3_od_stable", bus.out_data, 8'h22);
        base = m_cons.size();
        for (int i = 0; i < 8; i++) cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t3_drain_n", m_cons.size(), base + 5);
        for (int i = 0; i < 5; i++) check("t3_drain", m_cons[base+i], t3_exp[i]);

        // Simultaneous push/pop at count 2, then pointer wrap
        base = m_cons.size();
        cycle(1, 8'h01, 3'd0, 0, 0, 0);
        cycle(1, 8'h02, 3'd0, 0, 0, 0);
        cycle(1, 8'h03, 3'd0, 0, 0, 0);
        check("t4_count_pre", bus.count, 2);
        cycle(1, 8'h04, 3'd0, 0, 1, 0);
        check("t4_count_pp", bus.count, 2);
        for (int i = 0; i < 10; i++) cycle(1, 8'(8'h10 + i), 3'd0, i[0], 1, 0);
        check("t4_count_stream", bus.count, 2);
        for (int i = 0; i < 6; i++) cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t4_n", m_cons.size(), base + 14);
        for (int i = 0; i < 4; i++) check("t4_head_order", m_cons[base+i], 8'(i + 1));
        for (int i = 0; i < 10; i++) check("t4_wrap_order", m_cons[base+4+i], 8'(8'h10 + i));

        // Reset mid-operation discards everything
        cycle(1, 8'h31, 3'd0, 0, 0, 0);
        cycle(1, 8'h32, 3'd0, 0, 0, 0);
        cycle(1, 8'h33, 3'd0, 0, 0, 0);
        cycle(1, 8'h34, 3'd0, 0, 0, 0);
        check("t5_count_pre", bus.count, 3);
        check("t5_ov_pre", bus.out_valid, 1);
        cycle(1, 8'h35, 3'd0, 0, 0, 1);
        check("t5_count", bus.count, 0);
        check("t5_ov", bus.out_valid, 0);
        check("t5_od", bus.out_data, 0);
        check("t5_in_ready", bus.in_ready, 1);
        check_empty_outputs("t5");
        base = m_cons.size();
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t5_no_stale", m_cons.size(), base);
        check("t5_ov_after", bus.out_valid, 0);

        // Output drains while the FIFO is empty
        cycle(1, 8'h5A, 3'd2, 0, 0, 0);
        cycle(0, 8'h00, 3'd0, 0, 0, 0);
        check("t6_ov", bus.out_valid, 1);
        check("t6_od", bus.out_data, 8'h16);
        check("t6_count", bus.count, 0);
        check_empty_outputs("t6_pre");
        cycle(0, 8'h00, 3'd0, 0, 1, 0);
        check("t6_ov_fall", bus.out_valid, 0);
        check("t6_od_hold", bus.out_data, 8'h16);
        check_empty_outputs("t6");

        @(negedge clk);
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_request_queue.md
Name: shift_request_queue

Overview:
- Upstream issue stage for the team's combinational 8-bit shifter.
- Buffers shift requests (data, amount, direction) in a small FIFO using a valid/ready handshake.
- Presents the FIFO head to the shifter and registers the shifter's result into a held output stage with its own valid/ready handshake.
- Decouples the request producer from the result consumer; 2-cycle minimum latency.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, >= 2.
- DATA_W, 8: request/result data width.
- AMT_W, 3: shift amount width.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  queue can accept; equals !full.
- in_data  input  DATA_W  operand.
- in_amount  input  AMT_W  shift distance.
- in_dir  input  1  1 = left, 0 = right (logical, zero fill).
- shf_data  output  DATA_W  FIFO head operand to shifter; 0 when empty.
- shf_amount  output  AMT_W  FIFO head amount; 0 when empty.
- shf_dir  output  1  FIFO head direction; 0 when empty.
- shf_result  input  DATA_W  shifter result for the current shf_* (combinational path).
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer takes result.
- out_data  output  DATA_W  registered result.
- count  output  clog2(DEPTH)+1  FIFO occupancy; excludes the output register.

Behaviour:
- Reset, applied at a clk edge while rst=1:
  - Pointers and count reset to 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 1.
  - shf_* read 0 (empty).
  - rst dominates all other inputs.
- Reset mid-operation: all queued and output-held requests are discarded without completion.
- Push: in_valid && in_ready at an edge writes {in_data, in_amount, in_dir} at the write pointer. The write pointer increments mod DEPTH.
- Pop: at an edge, pop occurs when count != 0 && (!out_valid || out_ready). Then:
  - out_data <= shf_result.
  - out_valid <= 1.
  - The read pointer increments mod DEPTH.
- Output idle/hold:
  - If out_valid && out_ready with no pop, out_valid <= 0 and out_data holds its last value.
  - If out_valid && !out_ready, out_data and out_valid hold unchanged.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - When full, in_ready = 0 regardless of a same-cycle pop, so there is no push-through-full.
- No bypass:
  - A request pushed at edge k is at the head during cycle k→k+1 at the earliest, pops at edge k+1, and out_valid is high from k+1.
  - Minimum latency is 2 edges from acceptance to consumption at edge k+2.
- Throughput: with out_ready held at 1, one result per cycle.
- Maximum buffering: DEPTH entries in the FIFO plus 1 in the output register.
- Count encoding: count ranges 0..DEPTH. full = (count == DEPTH), empty = (count == 0).
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally; exercised after DEPTH pushes.
- Width rules: no arithmetic on data.
  - shf_result is trusted as the shift of the head entry.
  - Amounts are 0..(2^AMT_W − 1); amount 0 passes data unchanged.
- Ignored inputs: in_valid while in_ready = 0 is ignored with no state change; in_data content is don't-care when in_valid = 0.

Test Plan:
- Reset, then push {0x81, 1, left} with out_ready=1 → out_valid high 1 cycle after acceptance edge, out_data = 0x02, count returns to 0.
- Back-to-back {0xF0, 4, right}, {0x0F, 3, left}, {0xA5, 0, right} with out_ready=1 → out_data sequence 0x0F, 0x78, 0xA5 on consecutive cycles, no bubbles.
- out_ready=0, push continuously → 5 requests accepted (1 in output register + 4 in FIFO), in_ready=0 with count=4. The unaccepted 6th pushed value must not appear later. First result holds stable. Raise out_ready → 5 results drain in order, one per cycle.
- Steady state with count=2: assert push and pop on the same edge → count stays 2, order preserved. Then run 10 requests to force pointer wrap → FIFO order correct.
- Fill to count=3 with out_valid=1, assert rst for one edge (with in_valid also high) → next cycle count=0, out_valid=0, out_data=0, in_ready=1, shf_*=0. No stale result ever emerges.
- Empty queue with out_valid=1, out_ready=1 → out_valid falls next cycle, out_data unchanged; shf_* read 0 while empty.
